// File: rtl/mem_store_unit.sv
// ---------------------------------------------------------------------------
// mem_store_unit
//
// Store-side counterpart of the load extension path. Accepts a store
// (address, data, funct3) from the execute stage, steers the store bytes onto
// the 32-bit memory lanes with matching byte enables, and drives a req/ack
// data-memory write port.
//
// Build option:
//   MEM_STORE_SPLIT_EN  defined     -> stores that cross a word boundary are
//                                      issued as two aligned beats.
//                       not defined -> such stores are rejected with st_err
//                                      and no memory request is made.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   st_valid / st_ready   store handshake; st_ready is high only when idle
//   st_addr               byte address of the store
//   st_data               store data, right-aligned
//   st_func               funct3: 000 SB, 001 SH, 010 SW, others illegal
//   st_done               one-cycle pulse, store fully written
//   st_err                one-cycle pulse, store rejected, nothing written
//   mem_req / mem_ack     write beat request / beat accepted on this edge
//   mem_addr              word-aligned beat address
//   mem_wdata             lane-steered write data, unused lanes zero
//   mem_be                byte enables, bit i = byte lane i
// ---------------------------------------------------------------------------
module mem_store_unit #(
   parameter int unsigned WORD_LENGTH = 32,
   parameter int unsigned ADDR_WIDTH  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   st_valid,
   output logic                   st_ready,
   input  logic [ADDR_WIDTH-1:0]  st_addr,
   input  logic [WORD_LENGTH-1:0] st_data,
   input  logic [2:0]             st_func,
   output logic                   st_done,
   output logic                   st_err,
   output logic                   mem_req,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic [WORD_LENGTH-1:0] mem_wdata,
   output logic [3:0]             mem_be,
   input  logic                   mem_ack
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BEAT0 = 2'd1
`ifdef MEM_STORE_SPLIT_EN
      ,
      BEAT1 = 2'd2
`endif
   } state_t;

   state_t                 state_q;
   logic                   mem_req_q;
   logic [ADDR_WIDTH-1:0]  mem_addr_q;
   logic [WORD_LENGTH-1:0] mem_wdata_q;
   logic [3:0]             mem_be_q;
   logic                   st_done_q;
   logic                   st_err_q;
`ifdef MEM_STORE_SPLIT_EN
   logic [WORD_LENGTH-1:0] hi_data_q;
   logic [3:0]             hi_be_q;
   logic [WORD_LENGTH-1:0] hi_data_d;
`endif

   // Decode of the store presented on the request port
   logic [1:0]             off_d;
   logic                   func_ok_d;
   logic [3:0]             mask_d;
   logic [WORD_LENGTH-1:0] data_m_d;
   logic [7:0]             be_sh_d;
   logic [WORD_LENGTH-1:0] lo_data_d;
   logic [3:0]             lo_be_d;
   logic [3:0]             hi_be_d;
   logic                   reject_d;

   always_comb begin
      off_d     = st_addr[1:0];
      func_ok_d = 1'b1;
      mask_d    = '0;
      data_m_d  = '0;
      // Data is trimmed to the access size so unused lanes stay zero
      case (st_func)
         3'b000: begin
            mask_d   = 4'b0001;
            data_m_d = {{(WORD_LENGTH-8){1'b0}}, st_data[7:0]};
         end
         3'b001: begin
            mask_d   = 4'b0011;
            data_m_d = {{(WORD_LENGTH-16){1'b0}}, st_data[15:0]};
         end
         3'b010: begin
            mask_d   = 4'b1111;
            data_m_d = st_data;
         end
         default: func_ok_d = 1'b0;
      endcase

      be_sh_d = {4'b0000, mask_d} << off_d;
      lo_be_d = be_sh_d[3:0];
      hi_be_d = be_sh_d[7:4];

`ifdef MEM_STORE_SPLIT_EN
      {hi_data_d, lo_data_d} = {{WORD_LENGTH{1'b0}}, data_m_d} << {off_d, 3'b000};
      reject_d = !func_ok_d;
`else
      lo_data_d = data_m_d << {off_d, 3'b000};
      // Anything spilling into the next word cannot be written in this build
      reject_d  = !func_ok_d || (hi_be_d != 4'b0000);
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_be_q    <= '0;
         st_done_q   <= 1'b0;
         st_err_q    <= 1'b0;
`ifdef MEM_STORE_SPLIT_EN
         hi_data_q   <= '0;
         hi_be_q     <= '0;
`endif
      end else begin
         st_done_q <= 1'b0;
         st_err_q  <= 1'b0;
         case (state_q)
            IDLE: begin
               if (st_valid) begin
                  if (reject_d) begin
                     st_err_q <= 1'b1;
                  end else begin
                     state_q     <= BEAT0;
                     mem_req_q   <= 1'b1;
                     mem_addr_q  <= {st_addr[ADDR_WIDTH-1:2], 2'b00};
                     mem_wdata_q <= lo_data_d;
                     mem_be_q    <= lo_be_d;
`ifdef MEM_STORE_SPLIT_EN
                     hi_data_q   <= hi_data_d;
                     hi_be_q     <= hi_be_d;
`endif
                  end
               end
            end

            BEAT0: begin
               if (mem_ack) begin
`ifdef MEM_STORE_SPLIT_EN
                  if (hi_be_q != 4'b0000) begin
                     // Second beat follows immediately; mem_req stays high
                     state_q     <= BEAT1;
                     mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
                     mem_wdata_q <= hi_data_q;
                     mem_be_q    <= hi_be_q;
                  end else
`endif
                  begin
                     state_q     <= IDLE;
                     mem_req_q   <= 1'b0;
                     mem_addr_q  <= '0;
                     mem_wdata_q <= '0;
                     mem_be_q    <= '0;
                     st_done_q   <= 1'b1;
                  end
               end
            end

`ifdef MEM_STORE_SPLIT_EN
            BEAT1: begin
               if (mem_ack) begin
                  state_q     <= IDLE;
                  mem_req_q   <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  mem_be_q    <= '0;
                  st_done_q   <= 1'b1;
               end
            end
`endif

            default: begin
               state_q   <= IDLE;
               mem_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign st_ready  = (state_q == IDLE);
   assign st_done   = st_done_q;
   assign st_err    = st_err_q;
   assign mem_req   = mem_req_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_store_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_store_unit
//
// Directed and random stores against mem_store_unit. Expected beats come from
// a byte-by-byte model: every store byte is placed at its own byte address,
// and the word that address falls in decides which beat and lane it uses.
// Build with MEM_STORE_SPLIT_EN to match a split-enabled DUT.
// ---------------------------------------------------------------------------
module tb_mem_store_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        st_valid;
   logic        st_ready;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [2:0]  st_func;
   logic        st_done;
   logic        st_err;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;

   int unsigned checks = 0;
   int unsigned errors = 0;

`ifdef MEM_STORE_SPLIT_EN
   localparam bit SPLIT = 1'b1;
`else
   localparam bit SPLIT = 1'b0;
`endif

   mem_store_unit #(.WORD_LENGTH(32), .ADDR_WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .st_valid  (st_valid),
      .st_ready  (st_ready),
      .st_addr   (st_addr),
      .st_data   (st_data),
      .st_func   (st_func),
      .st_done   (st_done),
      .st_err    (st_err),
      .mem_req   (mem_req),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_be    (mem_be),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        err;
      logic        two;
      logic [31:0] a0;
      logic [31:0] a1;
      logic [31:0] wd0;
      logic [31:0] wd1;
      logic [3:0]  be0;
      logic [3:0]  be1;
   } exp_t;

   function automatic exp_t model(input logic [31:0] addr, input logic [31:0] data,
                                  input logic [2:0] f);
      exp_t        e;
      int unsigned n;
      logic [31:0] base;
      logic [31:0] ba;
      int unsigned lane;
      e = '0;
      case (f)
         3'b000:  n = 1;
         3'b001:  n = 2;
         3'b010:  n = 4;
         default: n = 0;
      endcase
      base = addr & 32'hFFFF_FFFC;
      e.a0 = base;
      e.a1 = base + 32'd4;
      for (int unsigned k = 0; k < n; k++) begin
         ba   = addr + k;
         lane = int'(ba[1:0]);
         if ((ba & 32'hFFFF_FFFC) == base) begin
            e.be0[lane]          = 1'b1;
            e.wd0[8*lane +: 8]   = data[8*k +: 8];
         end else begin
            e.two                = 1'b1;
            e.be1[lane]          = 1'b1;
            e.wd1[8*lane +: 8]   = data[8*k +: 8];
         end
      end
      if (n == 0 || (e.two && !SPLIT))
         e.err = 1'b1;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_beat(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
      chk("beat_req",   {31'b0, mem_req}, 32'd1);
      chk("beat_addr",  mem_addr, a);
      chk("beat_be",    {28'b0, mem_be}, {28'b0, be});
      chk("beat_wdata", mem_wdata, wd);
      chk("beat_nodone", {31'b0, st_done}, 32'd0);
      chk("beat_noready", {31'b0, st_ready}, 32'd0);
   endtask

   // Called #1 after the acceptance edge; returns #1 after the edge that
   // follows the st_done cycle.
   task automatic finish_store(input exp_t e, input int dly);
      int nb;
      nb = e.two ? 2 : 1;
      for (int b = 0; b < nb; b++) begin
         for (int w = 0; w <= dly; w++) begin
            if (b == 0) check_beat(e.a0, e.be0, e.wd0);
            else        check_beat(e.a1, e.be1, e.wd1);
            mem_ack = (w == dly);
            @(posedge clk); #1;
         end
         mem_ack = 1'b0;
      end
      chk("done_pulse",  {31'b0, st_done},  32'd1);
      chk("done_noreq",  {31'b0, mem_req},  32'd0);
      chk("done_ready",  {31'b0, st_ready}, 32'd1);
      chk("done_noerr",  {31'b0, st_err},   32'd0);
      @(posedge clk); #1;
      chk("done_clear",  {31'b0, st_done},  32'd0);
   endtask

   task automatic run_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [2:0] f, input int dly);
      exp_t e;
      e = model(a, d, f);
      @(negedge clk);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_func  = f;
      chk("ready_before", {31'b0, st_ready}, 32'd1);
      @(posedge clk); #1;
      st_valid = 1'b0;
      if (e.err) begin
         chk("err_pulse",  {31'b0, st_err},   32'd1);
         chk("err_noreq",  {31'b0, mem_req},  32'd0);
         chk("err_nodone", {31'b0, st_done},  32'd0);
         chk("err_ready",  {31'b0, st_ready}, 32'd1);
         @(posedge clk); #1;
         chk("err_clear",  {31'b0, st_err},   32'd0);
         chk("err_noreq2", {31'b0, mem_req},  32'd0);
      end else begin
         finish_store(e, dly);
      end
   endtask

   initial begin
      exp_t        e1;
      exp_t        e2;
      logic [31:0] ra;
      logic [2:0]  rf;
      int unsigned r;

      rst      = 1'b1;
      st_valid = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      st_func  = '0;
      mem_ack  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", {31'b0, st_ready}, 32'd1);
      chk("rst_req",   {31'b0, mem_req},  32'd0);
      chk("rst_done",  {31'b0, st_done},  32'd0);
      chk("rst_err",   {31'b0, st_err},   32'd0);
      chk("rst_addr",  mem_addr,          32'd0);
      chk("rst_wdata", mem_wdata,         32'd0);
      chk("rst_be",    {28'b0, mem_be},   32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases
      run_store(32'h0000_1003, 32'h0000_00AB, 3'b000, 0);
      run_store(32'h0000_2000, 32'hDEAD_BEEF, 3'b010, 3);
      run_store(32'h0000_2002, 32'h1122_3344, 3'b010, 0);
      run_store(32'h0000_5000, 32'h1234_5678, 3'b011, 0);
      run_store(32'h0000_5001, 32'h1234_5678, 3'b111, 1);
      run_store(32'h0000_4001, 32'hFFFF_A55A, 3'b001, 1);
      run_store(32'h0000_4003, 32'h0000_C0DE, 3'b001, 0);
      run_store(32'hFFFF_FFFE, 32'hCAFE_F00D, 3'b010, 1);
      run_store(32'h0000_6001, 32'h89AB_CDEF, 3'b010, 2);

      // Async reset while a beat is waiting for ack
      @(negedge clk);
      st_valid = 1'b1;
      st_addr  = SPLIT ? 32'h0000_3001 : 32'h0000_3000;
      st_data  = 32'h0BAD_F00D;
      st_func  = 3'b010;
      @(posedge clk); #1;
      st_valid = 1'b0;
      if (SPLIT) begin
         mem_ack = 1'b1;
         @(posedge clk); #1;
         mem_ack = 1'b0;
      end
      chk("rst_mid_req_pre", {31'b0, mem_req}, 32'd1);
      chk("rst_mid_addr_pre", mem_addr, SPLIT ? 32'h0000_3004 : 32'h0000_3000);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_req_async", {31'b0, mem_req},  32'd0);
      chk("rst_mid_ready",     {31'b0, st_ready}, 32'd1);
      chk("rst_mid_nodone",    {31'b0, st_done},  32'd0);
      @(posedge clk); #1;
      chk("rst_mid_nodone2",   {31'b0, st_done},  32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("rst_rel_ready",  {31'b0, st_ready}, 32'd1);
      chk("rst_rel_nodone", {31'b0, st_done},  32'd0);
      chk("rst_rel_req",    {31'b0, mem_req},  32'd0);
      run_store(32'h0000_7002, 32'h0000_0077, 3'b000, 0);

      // st_valid held high: second store accepted in the st_done cycle of the first
      e1 = model(32'h0000_0010, 32'h0000_005A, 3'b000);
      e2 = model(32'h0000_0012, 32'h0000_BEEF, 3'b001);
      @(negedge clk);
      st_valid = 1'b1;
      st_addr  = 32'h0000_0010;
      st_data  = 32'h0000_005A;
      st_func  = 3'b000;
      @(posedge clk); #1;
      check_beat(e1.a0, e1.be0, e1.wd0);
      mem_ack = 1'b1;
      st_addr = 32'h0000_0012;
      st_data = 32'h0000_BEEF;
      st_func = 3'b001;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      chk("b2b_done",  {31'b0, st_done},  32'd1);
      chk("b2b_ready", {31'b0, st_ready}, 32'd1);
      @(posedge clk); #1;
      st_valid = 1'b0;
      finish_store(e2, 0);

      // Random stores
      for (int i = 0; i < 60; i++) begin
         r  = $urandom_range(0, 7);
         rf = (r < 6) ? 3'(r % 3) : 3'($urandom_range(3, 7));
         ra = (i % 10 == 9) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3))) : $urandom;
         run_store(ra, $urandom, rf, int'($urandom_range(0, 2)));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
